// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU blocks: FSM state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder slice shared by the bit-serial arithmetic blocks.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum and carry of three one-bit inputs.
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor: a - b computed as a + ~b + 1,
// one bit per clock through a single full-adder slice.
//
// Handshake: an operand pair transfers on a rising edge where in_valid_i and
// in_ready_o are both high; a result transfers on a rising edge where
// out_valid_o and out_ready_i are both high. in_ready_o is high only in IDLE,
// out_valid_o only in DONE, so the two transfers never share a cycle.
module serial_sub16
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] res_next;

    full_adder u_slice (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (sum_bit),
        .c_o (carry_out)
    );

    // Result register after this cycle's sum bit enters at the MSB.
    assign res_next = {sum_bit, res_q[WIDTH-1:1]};

    // Next-state, datapath and flag update logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = ~b_i;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    sa_d    = a_i[WIDTH-1];
                    sb_d    = b_i[WIDTH-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = res_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Final bit: freeze the flags alongside the result.
                    zr_d     = (res_next == '0);
                    ng_d     = res_next[WIDTH-1];
                    borrow_d = ~carry_out;
                    ovf_d    = (sa_q != sb_q) && (res_next[WIDTH-1] != sa_q);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign out_o       = res_q;
    assign zr_o        = zr_q;
    assign ng_o        = ng_q;
    assign borrow_o    = borrow_q;
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Bench for serial_sub16: directed corner cases plus random operands, with an
// acceptance-side model feeding an expected queue and an output-side monitor.
module tb_serial_sub16;

    localparam int W = 16;
    localparam int SMAX = (2 ** (W - 1)) - 1;
    localparam int SMIN = -(2 ** (W - 1));

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic         borrow;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

    logic [W+3:0] exp_q[$];
    int           acc_q[$];
    int           acc_log[$];

    serial_sub16 #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out),
        .zr_o        (zr),
        .ng_o        (ng),
        .borrow_o    (borrow),
        .ovf_o       (ovf),
        .dbg_state_o (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int           sx, sy, sd;
        logic         m_zr, m_ng, m_br, m_ov;
        d    = x - y;
        sx   = $signed(x);
        sy   = $signed(y);
        sd   = sx - sy;
        m_zr = (d == 0);
        m_ng = (sd < 0) ? ((sd >= SMIN) ? 1'b1 : 1'b0) : ((sd > SMAX) ? 1'b1 : 1'b0);
        m_br = (int'(x) < int'(y));
        m_ov = (sd > SMAX) || (sd < SMIN);
        return {d, m_zr, m_ng, m_br, m_ov};
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: records acceptances, checks results, hold stability and handshake.
    initial begin
        logic         prev_valid;
        logic         prev_ready;
        logic         prev_handoff;
        logic [W+3:0] prev_bundle;
        logic [W+3:0] e;
        prev_valid   = 1'b0;
        prev_ready   = 1'b0;
        prev_handoff = 1'b0;
        prev_bundle  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_valid   = 1'b0;
                prev_ready   = 1'b0;
                prev_handoff = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(a, b));
                    acc_q.push_back(cyc);
                    acc_log.push_back(cyc);
                end
                if (out_valid) begin
                    chk("in_ready_low_while_valid", in_ready, 0);
                    if (!prev_valid) begin
                        if (acc_q.size() == 0) fail_now("spurious_out_valid");
                        else chk("latency", cyc - acc_q.pop_front(), W + 1);
                    end
                    if (prev_valid && !prev_ready)
                        chk("hold_stable", {out, zr, ng, borrow, ovf}, prev_bundle);
                    if (out_ready) begin
                        if (exp_q.size() == 0) fail_now("unexpected_result");
                        else begin
                            e = exp_q.pop_front();
                            chk("result", {out, zr, ng, borrow, ovf}, e);
                        end
                    end
                end
                if (prev_handoff)
                    chk("idle_after_handoff", {in_ready, out_valid}, 2'b10);
                prev_valid   = out_valid;
                prev_ready   = out_ready;
                prev_bundle  = {out, zr, ng, borrow, ovf};
                prev_handoff = out_valid && out_ready;
            end
        end
    end

    // Present an operand pair until accepted; optionally keep in_valid high.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        int t;
        bit got;
        t   = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = av;
        b = bv;
        while (!got && t < 200) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else t++;
        end
        if (!got) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("drain_timeout");
    endtask

    // Stimulus
    initial begin
        int seen;
        int t;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {out, zr, ng, borrow, ovf}, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of a run discards the operation.
        send(16'd100, 16'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("midrun_reset_outputs", {out, zr, ng, borrow, ovf, out_valid}, 0);
        chk("midrun_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        seen = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_valid_after_reset", seen, 0);

        // Directed corners with the consumer always ready.
        rdy_mode = 0;
        send(16'd100, 16'd58, 1'b0);
        send(16'd0, 16'd1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0);
        drain();

        // Zero result held under backpressure.
        rdy_mode = 1;
        send(16'h1234, 16'h1234, 1'b0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now("zero_valid_timeout");
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", {out_valid, in_ready}, 2'b10);
        end
        rdy_mode = 0;
        drain();

        // Back-to-back with in_valid held; operand edits mid-run must not matter.
        send(16'd5, 16'd3, 1'b1);
        send(16'd3, 16'd5, 1'b0);
        if (acc_log.size() >= 2)
            chk("b2b_interval", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], W + 2);
        else
            fail_now("b2b_missing_accept");
        drain();

        // Random operands with random consumer backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), W'($urandom), 1'b0);
        end
        rdy_mode = 0;
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
